// File: rtl/sat_add_arbiter_pkg.sv
// Shared constants and state encoding for the shared Q5.15 saturating adder.
// Q5.15 layout: 1 sign bit, 5 integer bits, 15 fraction bits.
package sat_add_arbiter_pkg;

    localparam int INT_W    = 5;
    localparam int FRAC_W   = 15;
    localparam int SIZE_DEF = 1 + INT_W + FRAC_W;

    localparam logic [SIZE_DEF-1:0] SAT_MAX = 21'h0FFFFF;
    localparam logic [SIZE_DEF-1:0] SAT_MIN = 21'h100000;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/sat_add_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping at NREQ.
module sat_add_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IDW-1:0]  win_idx
);

    always_comb begin
        int  j;
        logic found;
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found      = 1'b1;
                win_oh[j]  = 1'b1;
                win_idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/sat_add_arbiter.sv
// One signed Q5.15 saturating adder shared round-robin between NREQ requesters.
// Define SAT_ADD_ARB_STATS_EN to build the saturation event counter.
module sat_add_arbiter
    import sat_add_arbiter_pkg::*;
#(
    parameter int SIZE = SIZE_DEF,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] op_a,
    input  logic [NREQ*SIZE-1:0] op_b,
    output logic [NREQ-1:0]      gnt,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic [SIZE-1:0]      sum,
    output logic                 sat,
    output logic                 busy,
    input  logic                 stat_clr,
    output logic [15:0]          sat_cnt
);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id_q;
    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;

    logic [NREQ-1:0] win_oh;
    logic [IDW-1:0]  win_idx;
    logic [SIZE-1:0] a_sel;
    logic [SIZE-1:0] b_sel;

    logic [SIZE-1:0] raw;
    logic            pos_ovf;
    logic            neg_ovf;
    logic [SIZE-1:0] sat_val;

    sat_add_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    // One-hot AND-OR mux keeps operand selection free of index arithmetic.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                a_sel = a_sel | op_a[i*SIZE +: SIZE];
                b_sel = b_sel | op_b[i*SIZE +: SIZE];
            end
        end
    end

    always_comb begin
        raw     = a_q + b_q;
        pos_ovf = ~a_q[SIZE-1] & ~b_q[SIZE-1] &  raw[SIZE-1];
        neg_ovf =  a_q[SIZE-1] &  b_q[SIZE-1] & ~raw[SIZE-1];
        sat_val = raw;
        if (pos_ovf) sat_val = SAT_MAX;
        if (neg_ovf) sat_val = SAT_MIN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            sum     <= '0;
            sat     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        a_q   <= a_sel;
                        b_q   <= b_sel;
                        id_q  <= win_idx;
                        gnt   <= win_oh;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    sum     <= sat_val;
                    sat     <= pos_ovf | neg_ovf;
                    done_id <= id_q;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    ptr     <= (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SAT_ADD_ARB_STATS_EN
    logic [15:0] cnt_q;

    // Counts at the same edge that publishes the saturated result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stat_clr) begin
            cnt_q <= '0;
        end else if (state == CALC && (pos_ovf | neg_ovf) && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign sat_cnt = cnt_q;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign sat_cnt         = '0;
`endif

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Directed bench for sat_add_arbiter: vector table of single-requester ops
// plus hand sequences for round-robin order, req drop, reset abort and stats.
module tb_sat_add_arbiter;

    localparam int SIZE = 21;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*SIZE-1:0] op_a;
    logic [NREQ*SIZE-1:0] op_b;
    logic [NREQ-1:0]      gnt;
    logic                 done;
    logic [IDW-1:0]       done_id;
    logic [SIZE-1:0]      sum;
    logic                 sat;
    logic                 busy;
    logic                 stat_clr;
    logic [15:0]          sat_cnt;

    int n_vec = 0;
    int n_bad = 0;

    sat_add_arbiter #(
        .SIZE (SIZE),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .op_a     (op_a),
        .op_b     (op_b),
        .gnt      (gnt),
        .done     (done),
        .done_id  (done_id),
        .sum      (sum),
        .sat      (sat),
        .busy     (busy),
        .stat_clr (stat_clr),
        .sat_cnt  (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic [20:0] a;
        logic [20:0] b;
        logic [20:0] s;
        logic        st;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        stat_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_op(input int k, input logic [20:0] a, input logic [20:0] b,
                         input logic [20:0] s, input logic st, input logic clr);
        logic [NREQ-1:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        req   = oh;
        op_a[k*SIZE +: SIZE] = a;
        op_b[k*SIZE +: SIZE] = b;
        tick();
        chk("gnt", 32'(gnt), 32'(oh));
        chk("busy", 32'(busy), 32'd1);
        chk("no_done_at_gnt", 32'(done), 32'd0);
        // Scramble operands after grant; the latched copies must be used.
        op_a[k*SIZE +: SIZE] = ~a;
        op_b[k*SIZE +: SIZE] = ~b;
        stat_clr = clr;
        tick();
        chk("done", 32'(done), 32'd1);
        chk("sum", 32'(sum), 32'(s));
        chk("sat", 32'(sat), 32'(st));
        chk("done_id", 32'(done_id), 32'(k));
        chk("no_gnt_at_done", 32'(gnt), 32'd0);
        req      = '0;
        stat_clr = 1'b0;
        tick();
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        logic [20:0] ea;
        int          e;
        rst_n    = 1'b0;
        req      = '0;
        op_a     = '0;
        op_b     = '0;
        stat_clr = 1'b0;

        tv[0] = '{0, 21'h008000, 21'h008000, 21'h010000, 1'b0};
        tv[1] = '{0, 21'h0FFFFF, 21'h000001, 21'h0FFFFF, 1'b1};
        tv[2] = '{0, 21'h100000, 21'h1FFFFF, 21'h100000, 1'b1};
        tv[3] = '{1, 21'h1FFFFF, 21'h000001, 21'h000000, 1'b0};
        tv[4] = '{2, 21'h00C000, 21'h1FC000, 21'h008000, 1'b0};
        tv[5] = '{3, 21'h080000, 21'h080000, 21'h0FFFFF, 1'b1};
        tv[6] = '{3, 21'h180000, 21'h180000, 21'h100000, 1'b0};
        tv[7] = '{1, 21'h0FFFFF, 21'h100000, 21'h1FFFFF, 1'b0};

        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            do_op(tv[i].k, tv[i].a, tv[i].b, tv[i].s, tv[i].st, 1'b0);

        // All requesters held high from ptr=0: ids 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i*SIZE +: SIZE] = 21'h001000 * 21'(i + 1);
            op_b[i*SIZE +: SIZE] = 21'h000100;
        end
        req = 4'b1111;
        for (int c = 1; c <= 10; c++) begin
            tick();
            e  = ((c - 1) / 2) % NREQ;
            ea = 21'h001000 * 21'(e + 1) + 21'h000100;
            if (c % 2 == 1) begin
                chk("rr_gnt", 32'(gnt), 32'(1 << e));
                chk("rr_no_done", 32'(done), 32'd0);
            end else begin
                chk("rr_done", 32'(done), 32'd1);
                chk("rr_done_id", 32'(done_id), 32'(e));
                chk("rr_sum", 32'(sum), 32'(ea));
                chk("rr_no_gnt", 32'(gnt), 32'd0);
            end
        end
        req = '0;

        // ptr=1 now; req2 wins, then drops during CALC.
        req = 4'b1100;
        tick();
        chk("drop_gnt", 32'(gnt), 32'b0100);
        req = 4'b1000;
        tick();
        chk("drop_done", 32'(done), 32'd1);
        chk("drop_done_id", 32'(done_id), 32'd2);
        req = 4'b1011;
        tick();
        chk("next_from_3", 32'(gnt), 32'b1000);
        tick();
        chk("next_done_id", 32'(done_id), 32'd3);
        chk("next_sum", 32'(sum), 32'h004100);
        req = '0;
        tick();

        // Reset while in CALC aborts the operation.
        op_a[0 +: SIZE] = 21'h008000;
        op_b[0 +: SIZE] = 21'h008000;
        req = 4'b0001;
        tick();
        chk("abort_gnt", 32'(gnt), 32'b0001);
        rst_n = 1'b0;
        tick();
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_gnt_clr", 32'(gnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_sat", 32'(sat), 32'd0);
        chk("abort_done_id", 32'(done_id), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("resume_gnt", 32'(gnt), 32'b0001);
        tick();
        chk("resume_done", 32'(done), 32'd1);
        chk("resume_sum", 32'(sum), 32'h010000);
        req = '0;
        tick();

`ifdef SAT_ADD_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++)
            do_op(0, 21'h0FFFFF, 21'h000001, 21'h0FFFFF, 1'b1, 1'b0);
        chk("sat_cnt_3", 32'(sat_cnt), 32'd3);
        do_op(0, 21'h100000, 21'h1FFFFF, 21'h100000, 1'b1, 1'b1);
        chk("sat_cnt_clr", 32'(sat_cnt), 32'd0);
`else
        stat_clr = 1'b1;
        do_op(0, 21'h0FFFFF, 21'h000001, 21'h0FFFFF, 1'b1, 1'b1);
        chk("sat_cnt_off", 32'(sat_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
